// File: rtl/rv32imc_types.sv
// Shared types for the rv32imc core: fetch FSM states, RVFI fetch info and
// the IF->ID pipeline register layout.
package rv32imc_types;

  localparam logic [3:0] IMEM_FULL_MASK = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,  // request driven this cycle
    WAIT  = 2'd1,  // request outstanding, response not yet seen
    HOLD  = 2'd2   // response captured, waiting for downstream to accept
  } fetch_state_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc_rdata;
    logic [31:0] pc_wdata;
  } rvfi_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    rvfi_t       rvfi;
  } if_stage_t;

  // Sequential next-PC; wraps modulo 2^32.
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, issues one word read at a time,
// holds a response across stalls and applies branch redirects, discarding
// any response that belongs to a fetch made before the redirect.
//
// Handshake: a request is the single cycle with imem_rmask = 4'hF; its
// response is the single imem_resp pulse in a later cycle. Downstream accepts
// if_stage_reg on a cycle with i_if_reg_we = 1; i_pc_we = 0 stalls the PC.
// i_flush wins over both stall and advance.
import rv32imc_types::*;

module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h1ECEB000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_pc_we,
  input  logic         i_if_reg_we,
  input  logic         i_flush,
  input  logic [31:0]  i_target,
  output logic [31:0]  imem_addr,
  output logic [3:0]   imem_rmask,
  input  logic         imem_resp,
  output if_stage_t    if_stage_reg,
  output fetch_state_t dbg_state
);

  fetch_state_t state, state_n;
  logic [31:0]  pc, pc_n;
  logic         redirect_pend, redirect_pend_n;
  logic [31:0]  redirect_q, redirect_q_n;
  if_stage_t    if_reg_n;
  logic [31:0]  target;
  logic         resp_ok;
  logic         adv;

  assign target     = i_target & ~32'h3;
  assign imem_addr  = pc;
  assign imem_rmask = (state == FETCH && !rst) ? IMEM_FULL_MASK : 4'h0;
  assign dbg_state  = state;

  // A response is usable when it arrives in WAIT or was parked in HOLD.
  assign resp_ok = (imem_resp && state == WAIT) || (state == HOLD);
  assign adv     = resp_ok && i_pc_we && i_if_reg_we && !redirect_pend && !i_flush;

  // Next-state, PC, redirect and pipeline-register selection.
  always_comb begin
    state_n         = state;
    pc_n            = pc;
    redirect_pend_n = redirect_pend;
    redirect_q_n    = redirect_q;
    if_reg_n        = if_stage_reg;
    case (state)
      FETCH: begin
        // The request just issued stays outstanding even on a flush, so the
        // redirect is parked until its response has been swallowed.
        state_n = WAIT;
        if (i_flush) begin
          redirect_q_n    = target;
          redirect_pend_n = 1'b1;
        end
      end
      WAIT: begin
        if (imem_resp) begin
          state_n = FETCH;
          if (i_flush) begin
            pc_n            = target;
            redirect_pend_n = 1'b0;
          end else if (redirect_pend) begin
            pc_n            = redirect_q;
            redirect_pend_n = 1'b0;
          end else if (adv) begin
            pc_n = pc_plus4(pc);
          end else begin
            state_n = HOLD;
          end
        end else if (i_flush) begin
          redirect_q_n    = target;
          redirect_pend_n = 1'b1;
        end
      end
      HOLD: begin
        if (i_flush) begin
          pc_n    = target;
          state_n = FETCH;
        end else if (adv) begin
          pc_n    = pc_plus4(pc);
          state_n = FETCH;
        end
      end
      default: state_n = FETCH;
    endcase

    if (i_flush) begin
      if_reg_n = '0;
    end else if (adv) begin
      if_reg_n.pc            = pc;
      if_reg_n.pc_next       = pc_plus4(pc);
      if_reg_n.rvfi.valid    = 1'b1;
      if_reg_n.rvfi.pc_rdata = pc;
      if_reg_n.rvfi.pc_wdata = pc_plus4(pc);
    end
  end

  // State, PC, redirect and IF/ID register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= FETCH;
      pc            <= RESET_PC;
      redirect_pend <= 1'b0;
      redirect_q    <= 32'h0;
      if_stage_reg  <= '0;
    end else begin
      state         <= state_n;
      pc            <= pc_n;
      redirect_pend <= redirect_pend_n;
      redirect_q    <= redirect_q_n;
      if_stage_reg  <= if_reg_n;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Randomized bench for if_stage against a transaction-level fetch model.
module tb_if_stage;
  import rv32imc_types::*;

  localparam logic [31:0] RST_PC = 32'h1ECEB000;
  localparam int NCYC = 3000;

  // Clock and DUT signals.
  logic         clk = 1'b0;
  logic         rst;
  logic         pc_we;
  logic         reg_we;
  logic         flush;
  logic [31:0]  target;
  logic [31:0]  imem_addr;
  logic [3:0]   imem_rmask;
  logic         imem_resp;
  if_stage_t    if_reg;
  fetch_state_t dbg_state;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(RST_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_pc_we      (pc_we),
    .i_if_reg_we  (reg_we),
    .i_flush      (flush),
    .i_target     (target),
    .imem_addr    (imem_addr),
    .imem_rmask   (imem_rmask),
    .imem_resp    (imem_resp),
    .if_stage_reg (if_reg),
    .dbg_state    (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: addresses the model expects to be requested, in order.
  logic [31:0] exp_q[$];

  // Model: PC, whether a fetch is in flight, whether a response is parked,
  // and a pending redirect that waits for the stale response to come back.
  logic [31:0] m_pc;
  logic [31:0] m_redir;
  bit          m_out;
  bit          m_held;
  bit          m_pend;
  if_stage_t   m_reg;
  int          lat;
  int          max_lat;

  task automatic check_eq(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance the model across one clock edge using the inputs now driven.
  task automatic model_step();
    bit have_resp;
    bit req_now;
    if (rst) begin
      m_pc = RST_PC; m_out = 0; m_held = 0; m_pend = 0; m_redir = 0; m_reg = '0;
      return;
    end
    have_resp = m_held || (m_out && imem_resp);
    req_now   = !m_out && !m_held;
    if (flush) begin
      m_reg = '0;
      if (have_resp) begin
        m_pc = target & ~32'h3; m_out = 0; m_held = 0; m_pend = 0;
      end else begin
        m_pend = 1; m_redir = target & ~32'h3;
      end
    end else if (have_resp && m_pend) begin
      m_pc = m_redir; m_pend = 0; m_out = 0; m_held = 0;
    end else if (have_resp) begin
      m_out = 0;
      if (pc_we && reg_we) begin
        m_reg.pc = m_pc; m_reg.pc_next = m_pc + 32'd4;
        m_reg.rvfi.valid = 1'b1; m_reg.rvfi.pc_rdata = m_pc; m_reg.rvfi.pc_wdata = m_pc + 32'd4;
        m_pc = m_pc + 32'd4; m_held = 0;
      end else begin
        m_held = 1;
      end
    end
    if (req_now) begin
      m_out = 1;
      lat = $urandom_range(0, max_lat);
    end
  endtask

  // Stimulus, checking and summary.
  initial begin
    logic [3:0]   exp_rmask;
    fetch_state_t exp_state;
    logic [31:0]  exp_addr;
    int           r;
    rst = 1; pc_we = 1; reg_we = 1; flush = 0; target = 0; imem_resp = 0;
    max_lat = 0; lat = 0;
    model_step();
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      exp_rmask = (!rst && !m_out && !m_held) ? 4'hF : 4'h0;
      exp_state = m_held ? HOLD : (m_out ? WAIT : FETCH);
      if (exp_rmask == 4'hF) exp_q.push_back(m_pc);
      check_eq("rmask", {156'd0, imem_rmask}, {156'd0, exp_rmask});
      check_eq("addr", {128'd0, imem_addr}, {128'd0, m_pc});
      check_eq("if_reg", {31'd0, if_reg}, {31'd0, m_reg});
      check_eq("state", {158'd0, dbg_state}, {158'd0, exp_state});
      if (imem_rmask == 4'hF) begin
        check_eq("req_expected", {159'd0, exp_q.size() != 0}, 160'd1);
        if (exp_q.size() != 0) begin
          exp_addr = exp_q.pop_front();
          check_eq("req_addr", {128'd0, imem_addr}, {128'd0, exp_addr});
        end
      end

      // Next inputs: reset, then a clean streaming phase, then random traffic.
      if (cyc < 3) begin
        rst = 1;
      end else if (cyc < 40) begin
        rst = 0; pc_we = 1; reg_we = 1; flush = 0; max_lat = 0;
      end else begin
        rst    = ($urandom_range(0, 99) == 0);
        pc_we  = ($urandom_range(0, 9) < 8);
        reg_we = ($urandom_range(0, 3) != 0);
        flush  = ($urandom_range(0, 9) == 0);
        max_lat = 3;
      end
      r = $urandom_range(0, 7);
      if (r == 0)      target = 32'hFFFFFFFC;
      else if (r == 1) target = 32'hFFFFFFFD;
      else             target = RST_PC + ($urandom_range(0, 1023) << 2) + $urandom_range(0, 3);

      imem_resp = 0;
      if (m_out && !rst) begin
        if (lat == 0) imem_resp = 1;
        else lat--;
      end
      model_step();
    end
    @(negedge clk);
    check_eq("queue_drained", {128'd0, exp_q.size()}, 160'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
